// File: rtl/data_memory_pkg.sv
// Shared types and default geometry for the line-oriented data memory.
// Line index is taken from byte-address bits [IDX_HI:IDX_LO].
package data_memory_pkg;

  localparam int MEM_LATENCY = 10;
  localparam int DEPTH       = 512;
  localparam int LINE_W      = 256;
  localparam int ADDR_W      = 32;
  localparam int IDX_HI      = 13;
  localparam int IDX_LO      = 5;
  localparam int IDX_W       = IDX_HI - IDX_LO + 1;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

endpackage

// File: rtl/data_memory.sv
// Fixed-latency line memory: one request at a time, completion strobed by
// ack_o MEM_LATENCY cycles after acceptance; address/data sampled only at ack.
module data_memory
  import data_memory_pkg::state_e;
  import data_memory_pkg::IDLE;
  import data_memory_pkg::WAIT;
  import data_memory_pkg::IDX_HI;
  import data_memory_pkg::IDX_LO;
  import data_memory_pkg::IDX_W;
  import data_memory_pkg::ADDR_W;
#(
  parameter int MEM_LATENCY = data_memory_pkg::MEM_LATENCY,
  parameter int DEPTH       = data_memory_pkg::DEPTH,
  parameter int LINE_W      = data_memory_pkg::LINE_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [LINE_W-1:0] data_i,
  input  logic              enable_i,
  input  logic              write_i,
  output logic              ack_o,
  output logic [LINE_W-1:0] data_o
);

  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

  logic [LINE_W-1:0] memory [DEPTH];

  state_e            state_q;
  logic [CNT_W-1:0]  count_q;
  logic [IDX_W-1:0]  index;
  logic              unused_addr;

  assign index       = addr_i[IDX_HI:IDX_LO];
  // Offset and upper bits are don't-care: addresses alias every 16 KB.
  assign unused_addr = ^{addr_i[ADDR_W-1:IDX_HI+1], addr_i[IDX_LO-1:0]};

  assign ack_o = (state_q == WAIT) && (count_q == CNT_LAST);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          count_q <= '0;
          if (enable_i) state_q <= WAIT;
        end
        WAIT: begin
          if (count_q == CNT_LAST) begin
            state_q <= IDLE;
            count_q <= '0;
          end else begin
            count_q <= count_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          count_q <= '0;
        end
      endcase
    end
  end

  // Storage is deliberately outside the reset domain so contents survive rst_i.
  always_ff @(posedge clk_i) begin
    if (ack_o && write_i) memory[index] <= data_i;
  end

  always_comb begin
    data_o = '0;
    if (ack_o && !write_i) data_o = memory[index];
  end

endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory: stimulus pushes expected ack cycle and
// read data; a negedge monitor pops and compares on every ack_o.
module tb_data_memory;
  import data_memory_pkg::*;

  localparam int LAT = 10;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [31:0]  addr = '0;
  logic [255:0] wdata = '0;
  logic         en = 1'b0;
  logic         wr = 1'b0;
  logic         ack;
  logic [255:0] rdata;

  data_memory dut (
    .clk_i    (clk),
    .rst_i    (rst_n),
    .addr_i   (addr),
    .data_i   (wdata),
    .enable_i (en),
    .write_i  (wr),
    .ack_o    (ack),
    .data_o   (rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string        name;
    int           ack_cyc;
    logic [255:0] data;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  function automatic void chk(string name, logic [255:0] act, logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endfunction

  function automatic logic [255:0] pre(int i);
    if (i == 0) return 256'h5;
    return {8{32'(i) ^ 32'hA5A5_0000}};
  endfunction

  // Monitor: every ack must match the oldest outstanding expectation.
  logic prev_ack = 1'b0;
  exp_t e;
  always @(negedge clk) begin
    if (rst_n && ack) begin
      chk("ack_not_back_to_back", 256'(prev_ack), 256'd0);
      if (sb.size() == 0) begin
        chk("unexpected_ack", 256'd1, 256'd0);
      end else begin
        e = sb.pop_front();
        chk({e.name, "_ack_cycle"}, 256'(cyc), 256'(e.ack_cyc));
        chk({e.name, "_data"}, rdata, e.data);
        $display("txn %s ack_cyc=%0d data_o=%h", e.name, cyc, rdata);
      end
    end
    prev_ack = ack;
  end

  task automatic wait_ack(string name);
    for (int i = 0; i < 30 && !ack; i++) @(negedge clk);
    if (!ack) chk({name, "_ack_timeout"}, 256'd0, 256'd1);
    @(negedge clk);
  endtask

  task automatic issue(input logic [31:0] a, input logic [255:0] d, input logic w,
                       input string name, input logic [255:0] expd);
    @(negedge clk);
    addr  = a;
    wdata = d;
    wr    = w;
    en    = 1'b1;
    sb.push_back('{name, cyc + LAT, expd});
    @(negedge clk);
    en = 1'b0;  // dropping enable mid-WAIT must not abort
    wait_ack(name);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int acks;
  int quiet_bad;
  int c0;

  initial begin
    for (int i = 0; i < DEPTH; i++) dut.memory[i] = pre(i);

    // Reset state, with enable asserted to show it is ignored under reset.
    en = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_ack", 256'(ack), 256'd0);
    chk("reset_data", rdata, 256'd0);
    chk("reset_state", 256'(dut.state_q), 256'(IDLE));
    en = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    issue(32'h0000_0000, '0, 1'b0, "rd_0x0", 256'h5);
    issue(32'h0000_0400, 256'hDEADBEEF, 1'b1, "wr_0x400", 256'd0);
    chk("mem32_written", dut.memory[32], 256'hDEADBEEF);
    chk("mem31_untouched", dut.memory[31], pre(31));
    chk("mem33_untouched", dut.memory[33], pre(33));
    issue(32'h0000_0400, '0, 1'b0, "rd_0x400", 256'hDEADBEEF);
    issue(32'h0000_041F, '0, 1'b0, "rd_0x41F", 256'hDEADBEEF);
    issue(32'h0000_4400, '0, 1'b0, "rd_0x4400", 256'hDEADBEEF);
    issue(32'h0000_401F, '0, 1'b0, "rd_0x401F", 256'h5);
    chk("mem0_after_reads", dut.memory[0], 256'h5);

    // Back-to-back: enable held; second request accepted one idle cycle later.
    @(negedge clk);
    c0   = cyc;
    addr = 32'h0;
    wr   = 1'b0;
    en   = 1'b1;
    sb.push_back('{"b2b_first", c0 + LAT, 256'h5});
    sb.push_back('{"b2b_second", c0 + 2 * LAT + 1, 256'hDEADBEEF});
    repeat (LAT + 1) @(negedge clk);
    addr = 32'h0000_4400;
    @(negedge clk);
    en = 1'b0;
    wait_ack("b2b_second");

    // Reset at count 5 of a write to line 64: abort, no write.
    @(negedge clk);
    addr  = 32'h0000_0800;
    wdata = 256'hFEED_FACE;
    wr    = 1'b1;
    en    = 1'b1;
    @(negedge clk);
    en = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_abort_count", 256'(dut.count_q), 256'd5);
    rst_n = 1'b0;
    #1;
    chk("abort_ack_in_reset", 256'(ack), 256'd0);
    chk("abort_data_in_reset", rdata, 256'd0);
    chk("abort_state_in_reset", 256'(dut.state_q), 256'(IDLE));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    acks = 0;
    repeat (15) begin
      @(negedge clk);
      if (ack) acks++;
    end
    chk("abort_no_ack", 256'(acks), 256'd0);
    chk("abort_mem64", dut.memory[64], pre(64));
    chk("abort_state_idle", 256'(dut.state_q), 256'(IDLE));
    chk("reset_kept_mem32", dut.memory[32], 256'hDEADBEEF);
    issue(32'h0000_0800, '0, 1'b0, "rd_0x800", pre(64));

    // Idle with write data presented but no enable.
    addr  = 32'h0000_0400;
    wdata = 256'h1234;
    wr    = 1'b1;
    en    = 1'b0;
    quiet_bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (ack !== 1'b0 || rdata !== 256'd0) quiet_bad++;
    end
    chk("idle_quiet", 256'(quiet_bad), 256'd0);
    chk("idle_mem32", dut.memory[32], 256'hDEADBEEF);

    chk("scoreboard_empty", 256'(sb.size()), 256'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
